// File: rtl/uart_rx.sv
// 8N1 UART byte receiver with 16x oversampling, a valid/ack holding register,
// framing-error and overrun pulses.
module uart_rx #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       dout_valid,
  input  logic       dout_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned DIV   = CLK_HZ / (BAUD * 16);
  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_e;

  logic [2:0]       rx_sync_q;
  logic             rx_s;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic [3:0]       tcnt_q, tcnt_d;
  logic [2:0]       bidx_q, bidx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             load_c;

  // rx_s goes low two edges after the first edge that captures a low rx
  assign rx_s = rx_sync_q[2];
  assign tick = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q    <= 3'b111;
      state_q      <= IDLE;
      div_q        <= '0;
      tcnt_q       <= '0;
      bidx_q       <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      rx_sync_q    <= {rx_sync_q[1:0], rx};
      state_q      <= state_d;
      div_q        <= div_d;
      tcnt_q       <= tcnt_d;
      bidx_q       <= bidx_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      busy_q       <= busy_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = tick ? '0 : div_q + DIV_W'(1);
    tcnt_d       = tcnt_q;
    bidx_d       = bidx_q;
    shift_d      = shift_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    load_c       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          div_d   = '0;
          tcnt_d  = '0;
        end
      end
      START: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd7) begin
            if (!rx_s) begin
              state_d = DATA;
              tcnt_d  = '0;
              bidx_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      DATA: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            tcnt_d  = '0;
            shift_d = {rx_s, shift_q[7:1]};
            bidx_d  = bidx_q + 3'd1;
            if (bidx_q == 3'd7) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tcnt_d = tcnt_q + 4'd1;
          if (tcnt_q == 4'd15) begin
            tcnt_d = '0;
            if (rx_s) begin
              load_c  = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A load wins over an ack; an unacked load on top of an unread byte is an overrun
    if (load_c) begin
      dout_d       = shift_q;
      dout_valid_d = 1'b1;
      overrun_d    = dout_valid_q && !dout_ack;
    end else if (dout_ack && dout_valid_q) begin
      dout_valid_d = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule
